// File: rtl/ecg_rate_ctrl.sv
// BPM-to-phase_step converter for ecg_wave: clamps the requested rate, multiplies it by
// STEP_PER_BPM with a serial shift-add, then slews phase_step toward the target on sample ticks.
module ecg_rate_ctrl #(
  parameter int                BPM_W        = 8,
  parameter int                STEP_W       = 32,
  parameter int                STEP_PER_BPM = 1491,
  parameter int                BPM_MIN      = 30,
  parameter int                BPM_MAX      = 220,
  parameter int                RESET_BPM    = 60,
  parameter logic [STEP_W-1:0] SLEW_MAX     = STEP_W'(1491)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BPM_W-1:0]  bpm_in,
  input  logic              bpm_valid,
  output logic              bpm_ready,
  input  logic              sample_tick,
  output logic [STEP_W-1:0] phase_step,
  output logic              locked,
  output logic              busy
);

  localparam int                CNT_W      = (BPM_W > 1) ? $clog2(BPM_W) : 1;
  localparam logic [STEP_W-1:0] RESET_STEP = STEP_W'(RESET_BPM * STEP_PER_BPM);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BPM_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_SLEW} state_t;

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic [STEP_W-1:0]  r_target;
  logic [STEP_W-1:0]  r_acc;
  logic [STEP_W-1:0]  r_addend;
  logic [BPM_W-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_locked;
  logic               r_busy;
  logic               r_ready;

  logic               w_xfer;
  logic [BPM_W-1:0]   w_bpm_clamped;
  logic [STEP_W-1:0]  w_acc_next;
  logic [STEP_W:0]    w_diff;
  logic [STEP_W:0]    w_mag;
  logic               w_within;

  assign w_xfer = bpm_valid && r_ready;

  always_comb begin
    w_bpm_clamped = bpm_in;
    if (bpm_in < BPM_W'(BPM_MIN))
      w_bpm_clamped = BPM_W'(BPM_MIN);
    else if (bpm_in > BPM_W'(BPM_MAX))
      w_bpm_clamped = BPM_W'(BPM_MAX);
  end

  // Multiplier is consumed LSB-first while the addend shifts left in step.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_addend : '0);

  // One extra bit keeps the difference signed without risk of wrap.
  assign w_diff   = {1'b0, r_target} - {1'b0, r_step};
  assign w_mag    = w_diff[STEP_W] ? (~w_diff + 1'b1) : w_diff;
  assign w_within = (w_mag <= {1'b0, SLEW_MAX});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_step   <= RESET_STEP;
      r_target <= RESET_STEP;
      r_acc    <= '0;
      r_addend <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_locked <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_xfer) begin
      // Accepted in IDLE or SLEW; an in-flight slew is abandoned and phase_step holds.
      r_state  <= S_MULT;
      r_mplier <= w_bpm_clamped;
      r_addend <= STEP_W'(STEP_PER_BPM);
      r_acc    <= '0;
      r_cnt    <= '0;
      r_locked <= 1'b0;
      r_busy   <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_MULT: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_addend <= r_addend << 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_target <= w_acc_next;
            r_state  <= S_SLEW;
            r_ready  <= 1'b1;
          end
        end
        S_SLEW: begin
          if (r_step == r_target) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b1;
            r_busy   <= 1'b0;
          end else if (sample_tick) begin
            if (w_within)
              r_step <= r_target;
            else if (w_diff[STEP_W])
              r_step <= r_step - SLEW_MAX;
            else
              r_step <= r_step + SLEW_MAX;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bpm_ready  = r_ready;
  assign phase_step = r_step;
  assign locked     = r_locked;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ecg_rate_ctrl.sv
// Directed bench for ecg_rate_ctrl: a wide-slew instance for the multiply/clamp table and a
// default instance for slew-rate, abort, same-rate and reset sequences.
module tb_ecg_rate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bpm_in = '0;
  logic        bpm_valid = 1'b0;
  logic        sample_tick = 1'b0;

  logic        f_ready, f_locked, f_busy;
  logic [31:0] f_step;
  logic        s_ready, s_locked, s_busy;
  logic [31:0] s_step;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ecg_rate_ctrl #(.SLEW_MAX(32'h8000_0000)) dut_fast (
    .clk(clk), .rst_n(rst_n), .bpm_in(bpm_in), .bpm_valid(bpm_valid), .bpm_ready(f_ready),
    .sample_tick(sample_tick), .phase_step(f_step), .locked(f_locked), .busy(f_busy)
  );

  ecg_rate_ctrl dut_slow (
    .clk(clk), .rst_n(rst_n), .bpm_in(bpm_in), .bpm_valid(bpm_valid), .bpm_ready(s_ready),
    .sample_tick(sample_tick), .phase_step(s_step), .locked(s_locked), .busy(s_busy)
  );

  typedef struct {
    logic [7:0]  bpm;
    logic [31:0] exp_step;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  // Slow-instance step may only move on a tick in SLEW with no transfer, by at most 1491.
  logic        mon_en = 1'b0;
  logic        s_move_ok = 1'b0;
  logic [31:0] s_prev = 32'd0;
  logic [31:0] s_delta;
  always @(posedge clk) s_move_ok <= sample_tick && s_busy && s_ready && !bpm_valid;
  always @(negedge clk) begin
    if (mon_en && s_step != s_prev) begin
      s_delta = (s_step > s_prev) ? s_step - s_prev : s_prev - s_step;
      n_cmp++;
      if (!s_move_ok || s_delta > 32'd1491) begin
        n_bad++;
        $display("FAIL step_move: got %0d->%0d (tick_in_slew=%0b) expected change only on tick, <=1491",
                 s_prev, s_step, s_move_ok);
      end
    end
    s_prev = s_step;
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bpm_valid = 1'b0;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // Presents one transfer cycle; returns at the negedge just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic with_tick);
    @(negedge clk);
    bpm_in = b;
    bpm_valid = 1'b1;
    sample_tick = with_tick;
    @(negedge clk);
    bpm_valid = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic wait_slow_slew();
    int n = 0;
    while (!(s_busy && s_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_slew: got timeout expected SLEW within 30 cycles");
    end
  endtask

  task automatic tick_n(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (period - 1) @(negedge clk);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int cnt;
    vecs[0] = '{8'd120, 32'd178920};
    vecs[1] = '{8'd0,   32'd44730};
    vecs[2] = '{8'd255, 32'd328020};
    vecs[3] = '{8'd30,  32'd44730};
    vecs[4] = '{8'd220, 32'd328020};
    vecs[5] = '{8'd29,  32'd44730};
    vecs[6] = '{8'd221, 32'd328020};
    vecs[7] = '{8'd31,  32'd46221};
    vecs[8] = '{8'd100, 32'd149100};

    do_reset();
    chk("reset_step", s_step, 32'd89460);
    chk("reset_locked", {31'd0, s_locked}, 32'd1);
    chk("reset_ready", {31'd0, s_ready}, 32'd1);
    chk("reset_busy", {31'd0, s_busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("reset_hold_step", s_step, 32'd89460);
    chk("reset_hold_locked", {31'd0, s_locked}, 32'd1);

    // Multiply/clamp table on the wide-slew instance, ticking every cycle
    for (int v = 0; v < 9; v++) begin
      send(vecs[v].bpm, 1'b0);
      cnt = 0;
      while (!f_ready && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_ready_low_cycles", v), cnt, 32'd8);
      sample_tick = 1'b1;
      cnt = 0;
      while (!f_locked && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      sample_tick = 1'b0;
      chk($sformatf("v%0d_locked", v), {31'd0, f_locked}, 32'd1);
      chk($sformatf("v%0d_bpm%0d_step", v, vecs[v].bpm), f_step, vecs[v].exp_step);
    end

    // 60 -> 120 BPM at default slew, one tick per 4 clocks
    do_reset();
    send(8'd120, 1'b0);
    wait_slow_slew();
    tick_n(59, 4);
    chk("slew59_step", s_step, 32'd177429);
    chk("slew59_locked", {31'd0, s_locked}, 32'd0);
    tick_n(1, 4);
    chk("slew60_step", s_step, 32'd178920);
    chk("slew60_locked", {31'd0, s_locked}, 32'd1);
    tick_n(5, 4);
    chk("post_lock_step", s_step, 32'd178920);

    // Abort mid-slew with a same-cycle tick, then glide to 90 BPM
    do_reset();
    send(8'd120, 1'b0);
    wait_slow_slew();
    tick_n(20, 4);
    chk("mid20_step", s_step, 32'd119280);
    send(8'd90, 1'b1);
    chk("abort_tick_step", s_step, 32'd119280);
    sample_tick = 1'b1;
    repeat (6) @(negedge clk);
    sample_tick = 1'b0;
    chk("mult_hold_step", s_step, 32'd119280);
    chk("mult_ready", {31'd0, s_ready}, 32'd0);
    wait_slow_slew();
    tick_n(9, 4);
    chk("to90_9_step", s_step, 32'd132699);
    tick_n(1, 4);
    chk("to90_10_step", s_step, 32'd134190);
    chk("to90_locked", {31'd0, s_locked}, 32'd1);

    // Same BPM: locks again without any tick
    send(8'd90, 1'b0);
    chk("same_busy", {31'd0, s_busy}, 32'd1);
    cnt = 0;
    while (!s_locked && cnt < 15) begin
      cnt++;
      @(negedge clk);
    end
    chk("same_locked", {31'd0, s_locked}, 32'd1);
    chk("same_step", s_step, 32'd134190);

    // Async reset during MULT
    do_reset();
    send(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mult_busy", {31'd0, f_busy}, 32'd0);
    chk("rst_mult_ready", {31'd0, f_ready}, 32'd1);
    chk("rst_mult_locked", {31'd0, f_locked}, 32'd1);
    chk("rst_mult_step", f_step, 32'd89460);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(8'd100, 1'b0);
    sample_tick = 1'b1;
    repeat (12) @(negedge clk);
    sample_tick = 1'b0;
    chk("after_rst_step", f_step, 32'd149100);

    // Async reset during SLEW
    do_reset();
    send(8'd120, 1'b0);
    wait_slow_slew();
    tick_n(5, 4);
    chk("pre_rst_slew_step", s_step, 32'd96915);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_slew_step", s_step, 32'd89460);
    chk("rst_slew_locked", {31'd0, s_locked}, 32'd1);
    chk("rst_slew_busy", {31'd0, s_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(8'd150, 1'b0);
    sample_tick = 1'b1;
    repeat (12) @(negedge clk);
    sample_tick = 1'b0;
    chk("after_rst2_step", f_step, 32'd223650);
    chk("after_rst2_locked", {31'd0, f_locked}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
